// File: rtl/elbeth_writeback_arbiter.sv
// Writeback arbiter: ALU-priority commit of ALU results and queued loads, plus a pending-write scoreboard.
// Latency ALU 1 cycle, load >= 2 cycles; loads are backpressured by mem_ready, and an offer while full is dropped and flagged.
module elbeth_writeback_arbiter #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd_addr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd_addr,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  output logic        id_rs1_busy,
  output logic        id_rs2_busy,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        ctrl_w_enable,
  output logic [2:0]  lq_count,
  output logic        lq_overflow
);

  localparam int PTR_W = $clog2(LQ_DEPTH);

  logic [4:0]       lq_addr [LQ_DEPTH];
  logic [31:0]      lq_data [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      pending;

  logic        push;
  logic        pop;
  logic        sel_vld;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // Depth is a power of two, so pointers wrap naturally.
  assign mem_ready = rst_n && (lq_count < 3'(LQ_DEPTH));
  assign push      = mem_valid && mem_ready;
  assign pop       = !alu_valid && (lq_count != 3'd0);
  assign sel_vld   = alu_valid || pop;
  assign sel_addr  = alu_valid ? alu_rd_addr : lq_addr[rd_ptr];
  assign sel_data  = alu_valid ? alu_data : lq_data[rd_ptr];

  assign id_rs1_busy = (id_rs1_addr != 5'd0) && pending[id_rs1_addr];
  assign id_rs2_busy = (id_rs2_addr != 5'd0) && pending[id_rs2_addr];

  always_ff @(posedge clk) begin
    if (push) begin
      lq_addr[wr_ptr] <= mem_rd_addr;
      lq_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      lq_count      <= 3'd0;
      lq_overflow   <= 1'b0;
      pending       <= 32'd0;
      rd_addr       <= 5'd0;
      rd_data       <= 32'd0;
      ctrl_w_enable <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   lq_count <= lq_count + 3'd1;
        2'b01:   lq_count <= lq_count - 3'd1;
        default: lq_count <= lq_count;
      endcase
      if (mem_valid && !mem_ready) lq_overflow <= 1'b1;

      if (sel_vld) begin
        rd_addr       <= sel_addr;
        rd_data       <= sel_data;
        ctrl_w_enable <= (sel_addr != 5'd0);
      end else begin
        ctrl_w_enable <= 1'b0;
      end

      // Set is applied after clear so a same-cycle issue to the committing register wins.
      begin
        logic [31:0] nxt;
        nxt = pending;
        if (sel_vld && sel_addr != 5'd0) nxt[sel_addr] = 1'b0;
        if (issue_valid && issue_rd_addr != 5'd0) nxt[issue_rd_addr] = 1'b1;
        nxt[0] = 1'b0;
        pending <= nxt;
      end
    end
  end

endmodule

// File: doc/elbeth_writeback_arbiter.md
ELBETH_WRITEBACK_ARBITER -- requirements
Module: elbeth_writeback_arbiter

Interface
REQ-001 Parameter LQ_DEPTH, default 2, SHALL set the load-result queue depth (legal: 2 or 4).
REQ-002 Clock and reset: one clock, `clk`, shared by all logic; reset `rst_n` is synchronous and active-low.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 alu_valid  in  1  single-cycle ALU result present this cycle.
REQ-006 alu_rd_addr  in  5  destination register of ALU result.
REQ-007 alu_data  in  32  ALU result value.
REQ-008 mem_valid  in  1  load result offered.
REQ-009 mem_rd_addr  in  5  destination register of load result.
REQ-010 mem_data  in  32  load result value.
REQ-011 mem_ready  out  1  load queue can accept this cycle.
REQ-012 issue_valid  in  1  instruction with destination issued this cycle.
REQ-013 issue_rd_addr  in  5  destination of issued instruction.
REQ-014 id_rs1_addr, id_rs2_addr  in  5 each  source registers being decoded.
REQ-015 id_rs1_busy, id_rs2_busy  out  1 each  source has a pending uncommitted write.
REQ-016 rd_addr  out  5  register-file write address (registered).
REQ-017 rd_data  out  32  register-file write data (registered).
REQ-018 ctrl_w_enable  out  1  register-file write strobe (registered).
REQ-019 lq_count  out  3  current load-queue occupancy.
REQ-020 lq_overflow  out  1  sticky: load offered while queue full.

Function
REQ-021 Load queue SHALL be a FIFO of LQ_DEPTH {addr, data} entries; push when mem_valid && mem_ready.
REQ-022 mem_ready SHALL equal (lq_count < LQ_DEPTH); no same-cycle push-when-full via pop.
REQ-023 Each cycle exactly one commit source SHALL be selected: ALU if alu_valid, else queue head if lq_count>0, else none.
REQ-024 ALU has no backpressure; a queued load SHALL wait while alu_valid is high (no starvation guarantee required).
REQ-025 Selected source SHALL pop (queue) and drive rd_addr/rd_data at the next edge: ALU latency 1 cycle, load latency min 2 cycles.
REQ-026 ctrl_w_enable SHALL be 1 for exactly one cycle per committed entry with address != 0; entries to x0 are consumed with ctrl_w_enable=0.
REQ-027 With no source selected, ctrl_w_enable SHALL be 0; rd_addr/rd_data hold previous values.
REQ-028 Simultaneous push and pop SHALL leave lq_count unchanged; FIFO pointers wrap modulo LQ_DEPTH.
REQ-029 mem_valid while !mem_ready SHALL drop the entry and set lq_overflow until reset.
REQ-030 Scoreboard: 31 pending bits (x1..x31); issue_valid with addr!=0 SHALL set pending[issue_rd_addr].
REQ-031 Commit of address A!=0 (selected this cycle) SHALL clear pending[A] at the same edge.
REQ-032 Set and clear of the same address in one cycle: set SHALL win.
REQ-033 id_rsN_busy SHALL be combinational = pending[id_rsN_addr], forced 0 for address 0.

Reset
REQ-034 While rst_n=0 at an edge: queue emptied, lq_count=0, pending cleared, lq_overflow=0, rd_addr=0, rd_data=0, ctrl_w_enable=0.
REQ-035 mem_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-036 Reset mid-operation SHALL discard queued loads without generating writes.

Verification
REQ-037 alu_valid, addr 5, data 0xDEADBEEF -> next cycle ctrl_w_enable=1, rd_addr=5, rd_data=0xDEADBEEF.
REQ-038 Same cycle alu_valid(addr 3) and mem_valid(addr 7, 0x11) -> ALU commits at cycle+1, load commits at cycle+2, lq_count 1 then 0.
REQ-039 Three loads back-to-back with alu_valid held high, LQ_DEPTH=2 -> mem_ready=0 on third, third dropped, lq_overflow=1.
REQ-040 issue_valid addr 9, id_rs1_addr=9 -> id_rs1_busy=1 until commit of addr 9, then 0; id_rs2_addr=0 -> busy always 0.
REQ-041 ALU commit to addr 0 -> ctrl_w_enable stays 0; commit of addr 4 with issue of addr 4 in the same cycle -> pending[4] stays 1.
REQ-042 Two loads queued, rst_n low one cycle -> no ctrl_w_enable pulses, lq_count=0, mem_ready=1 after release.
